// File: rtl/hpc1_mul_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : hpc1_mul_scheduler_if
//  Description : Request, randomness, multiplier and response bus for
//                hpc1_mul_scheduler. The slave modport is the scheduler's
//                view and the master modport is its environment's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hpc1_mul_scheduler_if #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    localparam int NQ = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int SW = NUM_SHARES * BIT_WIDTH;
    localparam int RW = (NUM_SHARES + NQ) * BIT_WIDTH;

    // Requester side
    logic [NUM_REQ-1:0]      in_req_valid;
    logic [NUM_REQ-1:0]      out_req_ready;
    logic [NUM_REQ*SW-1:0]   in_req_a;
    logic [NUM_REQ*SW-1:0]   in_req_b;
    // PRNG stream
    logic                    in_rand_valid;
    logic                    out_rand_ready;
    logic [RW-1:0]           in_rand;
    // Shared multiplier
    logic [SW-1:0]           out_mul_a;
    logic [SW-1:0]           out_mul_r;
    logic [SW-1:0]           out_mul_b;
    logic [NQ*BIT_WIDTH-1:0] out_mul_p;
    logic [SW-1:0]           in_mul_c;
    // Responses
    logic                    out_rsp_valid;
    logic [ID_W-1:0]         out_rsp_id;
    logic [SW-1:0]           out_rsp_c;
    logic                    out_busy;

    modport master (
        output in_req_valid, in_req_a, in_req_b, in_rand_valid, in_rand, in_mul_c,
        input  out_req_ready, out_rand_ready, out_mul_a, out_mul_r, out_mul_b,
               out_mul_p, out_rsp_valid, out_rsp_id, out_rsp_c, out_busy
    );

    modport slave (
        input  in_req_valid, in_req_a, in_req_b, in_rand_valid, in_rand, in_mul_c,
        output out_req_ready, out_rand_ready, out_mul_a, out_mul_r, out_mul_b,
               out_mul_p, out_rsp_valid, out_rsp_id, out_rsp_c, out_busy
    );
endinterface
`default_nettype wire

// File: rtl/hpc1_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hpc1_mul_scheduler
//  Description : Round-robin scheduler sharing one hpc1_mul among NUM_REQ
//                requesters. Issues a/r in cycle t, b/p in cycle t+1 and
//                returns the ID-tagged product in cycle t+2. One issue per
//                cycle, one fresh randomness word per multiplication.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpc1_mul_scheduler #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  wire logic              in_clock,
    input  wire logic              in_reset,
    hpc1_mul_scheduler_if.slave    bus
);
    localparam int NQ = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int SW = NUM_SHARES * BIT_WIDTH;
    localparam int RW = (NUM_SHARES + NQ) * BIT_WIDTH;

    // Stage registers
    logic [ID_W-1:0]         r_ptr;
    logic                    r_v1;
    logic [ID_W-1:0]         r_id1;
    logic [SW-1:0]           r_b1;
    logic [NQ*BIT_WIDTH-1:0] r_p1;
    logic                    r_v2;
    logic [ID_W-1:0]         r_id2;

    // Stage-0 combinational signals
    logic                    w_issue;
    logic                    w_found;
    logic [ID_W:0]           w_cand;
    logic [ID_W-1:0]         w_grant_idx;
    logic [ID_W-1:0]         w_ptr_next;
    logic [SW-1:0]           w_sel_a;
    logic [SW-1:0]           w_sel_b;
    logic [SW-1:0]           w_rand_r;
    logic [NQ*BIT_WIDTH-1:0] w_rand_p;

    assign w_issue  = (|bus.in_req_valid) & bus.in_rand_valid & in_reset;
    assign w_rand_r = bus.in_rand[SW-1:0];
    assign w_rand_p = bus.in_rand[RW-1:SW];
    assign w_sel_a  = bus.in_req_a[w_grant_idx*SW +: SW];
    assign w_sel_b  = bus.in_req_b[w_grant_idx*SW +: SW];

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.in_req_valid[w_cand[ID_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand[ID_W-1:0];
            end
        end
    end

    // Pointer advances past the granted requester, wrapping after the last one.
    always_comb begin
        w_ptr_next = w_grant_idx + 1'b1;
        if (w_grant_idx == ID_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end
    end

    // Issue side: operands are forced to zero when idle so the multiplier
    // never recombines stale shares.
    assign bus.out_req_ready  = w_issue ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign bus.out_rand_ready = w_issue;
    assign bus.out_mul_a      = w_issue ? w_sel_a  : '0;
    assign bus.out_mul_r      = w_issue ? w_rand_r : '0;

    // Second operand half and response; everything reads zero while in reset.
    assign bus.out_mul_b     = in_reset ? r_b1 : '0;
    assign bus.out_mul_p     = in_reset ? r_p1 : '0;
    assign bus.out_rsp_valid = r_v2 & in_reset;
    assign bus.out_rsp_id    = in_reset ? r_id2 : '0;
    assign bus.out_rsp_c     = (r_v2 & in_reset) ? bus.in_mul_c : '0;
    assign bus.out_busy      = (r_v1 | r_v2) & in_reset;

    // Pointer and the two-stage operand/ID pipeline.
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            r_ptr <= '0;
            r_v1  <= 1'b0;
            r_id1 <= '0;
            r_b1  <= '0;
            r_p1  <= '0;
            r_v2  <= 1'b0;
            r_id2 <= '0;
        end else begin
            r_v1  <= w_issue;
            r_id1 <= w_issue ? w_grant_idx : '0;
            r_b1  <= w_issue ? w_sel_b     : '0;
            r_p1  <= w_issue ? w_rand_p    : '0;
            r_v2  <= r_v1;
            r_id2 <= r_id1;
            if (w_issue) begin
                r_ptr <= w_ptr_next;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hpc1_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpc1_mul_scheduler
//  Description : Self-checking bench for hpc1_mul_scheduler with a small
//                behavioural GF(4) multiplier model on the multiplier port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpc1_mul_scheduler;
    localparam int NS  = 2;
    localparam int BW  = 2;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int SW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hpc1_mul_scheduler_if #(.NUM_SHARES(NS), .BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IDW)) bus();

    hpc1_mul_scheduler #(.NUM_SHARES(NS), .BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IDW)) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] a_arr [NR];
    logic [3:0] b_arr [NR];

    // Expected pipeline contents
    bit         e1_v = 1'b0, e2_v = 1'b0;
    logic [1:0] e1_id = '0, e2_id = '0;
    logic [3:0] e1_b = '0;
    logic [1:0] e1_p = '0;
    logic [1:0] e1_prod = '0, e2_prod = '0;

    // GF(4) multiply, x^2 = x + 1
    function automatic logic [1:0] gf4(input logic [1:0] x, input logic [1:0] y);
        gf4[0] = (x[0] & y[0]) ^ (x[1] & y[1]);
        gf4[1] = (x[1] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[1]);
    endfunction

    function automatic logic [1:0] unmask(input logic [3:0] s);
        unmask = s[3:2] ^ s[1:0];
    endfunction

    // Behavioural multiplier: a/r captured at the issue edge, product at the next.
    // Shares are offset by a constant so an idle output is never all-zero.
    logic [3:0] ma_q = '0, mr_q = '0, c_q = 4'hF;
    always @(posedge clk) begin
        ma_q <= bus.out_mul_a;
        mr_q <= bus.out_mul_r;
        c_q  <= {mr_q[1:0] ^ 2'b11,
                 gf4(unmask(ma_q), unmask(bus.out_mul_b)) ^ mr_q[1:0] ^ 2'b11};
    end
    assign bus.in_mul_c = c_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic rnd_v, input logic [5:0] rnd);
        bus.in_req_valid  = rv;
        bus.in_rand_valid = rnd_v;
        bus.in_rand       = rnd;
        for (int j = 0; j < NR; j++) begin
            bus.in_req_a[j*SW +: SW] = a_arr[j];
            bus.in_req_b[j*SW +: SW] = b_arr[j];
        end
    endtask

    // Called mid-cycle; compares all outputs, advances the model, moves to next cycle.
    task automatic check_cycle(input bit iss, input int k, input logic [5:0] rnd);
        logic [3:0] exp_oh;
        exp_oh = iss ? (4'b0001 << k) : 4'b0000;
        chk("req_ready",  bus.out_req_ready,  exp_oh);
        chk("rand_ready", bus.out_rand_ready, iss);
        chk("mul_a",      bus.out_mul_a,      iss ? a_arr[k] : 4'h0);
        chk("mul_r",      bus.out_mul_r,      iss ? rnd[3:0] : 4'h0);
        chk("mul_b",      bus.out_mul_b,      e1_b);
        chk("mul_p",      bus.out_mul_p,      e1_p);
        chk("rsp_valid",  bus.out_rsp_valid,  e2_v);
        chk("busy",       bus.out_busy,       e1_v | e2_v);
        if (e2_v) begin
            chk("rsp_id",   bus.out_rsp_id, e2_id);
            chk("rsp_prod", bus.out_rsp_c[3:2] ^ bus.out_rsp_c[1:0], e2_prod);
        end else begin
            chk("rsp_c_idle", bus.out_rsp_c, 4'h0);
        end
        e2_v    = e1_v;
        e2_id   = e1_id;
        e2_prod = e1_prod;
        e1_v    = iss;
        e1_id   = iss ? 2'(k) : 2'd0;
        e1_b    = iss ? b_arr[k] : 4'h0;
        e1_p    = iss ? rnd[5:4] : 2'd0;
        e1_prod = iss ? gf4(unmask(a_arr[k]), unmask(b_arr[k])) : 2'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready",  bus.out_req_ready,  4'h0);
        chk("rst_rand_ready", bus.out_rand_ready, 1'b0);
        chk("rst_mul_a",      bus.out_mul_a,      4'h0);
        chk("rst_mul_r",      bus.out_mul_r,      4'h0);
        chk("rst_mul_b",      bus.out_mul_b,      4'h0);
        chk("rst_mul_p",      bus.out_mul_p,      2'h0);
        chk("rst_rsp_valid",  bus.out_rsp_valid,  1'b0);
        chk("rst_rsp_id",     bus.out_rsp_id,     2'h0);
        chk("rst_rsp_c",      bus.out_rsp_c,      4'h0);
        chk("rst_busy",       bus.out_busy,       1'b0);
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       rnd_v;
        logic [5:0] rnd;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t vecs [18];
    bit   pend [NR];
    int   wait_cnt [NR];

    initial begin
        // Directed sequence starting from pointer 0 after reset
        vecs[0]  = '{4'b0001, 1'b1, 6'h25, 4'b0001};
        vecs[1]  = '{4'b0000, 1'b1, 6'h3F, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b0, 6'h00, 4'b0000};
        vecs[3]  = '{4'b1111, 1'b1, 6'h1A, 4'b0010};
        vecs[4]  = '{4'b1111, 1'b1, 6'h2B, 4'b0100};
        vecs[5]  = '{4'b1111, 1'b1, 6'h36, 4'b1000};
        vecs[6]  = '{4'b1111, 1'b1, 6'h09, 4'b0001};
        vecs[7]  = '{4'b1010, 1'b1, 6'h1C, 4'b0010};
        vecs[8]  = '{4'b1010, 1'b0, 6'h2E, 4'b0000};
        vecs[9]  = '{4'b1010, 1'b1, 6'h33, 4'b1000};
        vecs[10] = '{4'b0101, 1'b0, 6'h11, 4'b0000};
        vecs[11] = '{4'b0101, 1'b1, 6'h27, 4'b0001};
        vecs[12] = '{4'b0100, 1'b1, 6'h3C, 4'b0100};
        vecs[13] = '{4'b0001, 1'b1, 6'h05, 4'b0001};
        vecs[14] = '{4'b1001, 1'b1, 6'h1E, 4'b1000};
        vecs[15] = '{4'b0000, 1'b0, 6'h00, 4'b0000};
        vecs[16] = '{4'b0000, 1'b0, 6'h00, 4'b0000};
        vecs[17] = '{4'b0000, 1'b0, 6'h00, 4'b0000};

        // Masked operands: req0 a=2 b=3, req1 a=3 b=3, req2 a=1 b=2, req3 a=2 b=2
        a_arr[0] = 4'h7; b_arr[0] = 4'h9;
        a_arr[1] = 4'h6; b_arr[1] = 4'h3;
        a_arr[2] = 4'hB; b_arr[2] = 4'hD;
        a_arr[3] = 4'h8; b_arr[3] = 4'hD;

        // Power-on reset, with requests and randomness present
        drive(4'b0000, 1'b0, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        drive(4'b1111, 1'b1, 6'h3F);
        #4;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 18; i++) begin
            int k;
            k = 0;
            for (int j = 0; j < NR; j++) if (vecs[i].exp_ready[j]) k = j;
            drive(vecs[i].rv, vecs[i].rnd_v, vecs[i].rnd);
            #4;
            check_cycle(|vecs[i].exp_ready, k, vecs[i].rnd);
        end

        // Reset one cycle after an issue: in-flight op discarded, pointer back to 0
        drive(4'b0001, 1'b1, 6'h12);
        #4;
        check_cycle(1'b1, 0, 6'h12);
        rst_n = 1'b0;
        drive(4'b0101, 1'b1, 6'h2A);
        #4;
        check_reset_outputs();
        @(posedge clk);
        #1;
        #4;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e1_v = 1'b0; e2_v = 1'b0; e1_id = '0; e2_id = '0;
        e1_b = '0;   e1_p = '0;   e1_prod = '0; e2_prod = '0;
        drive(4'b0101, 1'b1, 6'h15);
        #4;
        check_cycle(1'b1, 0, 6'h15);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 6'h00);
            #4;
            check_cycle(1'b0, 0, 6'h00);
        end

        // Constrained random stream: legal grants, ordered products, bounded waits
        for (int j = 0; j < NR; j++) begin
            pend[j] = 1'b0;
            wait_cnt[j] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0] rv;
            logic       rnd_v;
            logic [5:0] rnd;
            bit         iss;
            int         k;
            for (int j = 0; j < NR; j++) begin
                if (!pend[j] && ($urandom_range(0, 1) == 1)) begin
                    pend[j]     = 1'b1;
                    a_arr[j]    = 4'($urandom);
                    b_arr[j]    = 4'($urandom);
                    wait_cnt[j] = 0;
                end
                rv[j] = pend[j];
            end
            rnd_v = ($urandom_range(0, 3) != 0);
            rnd   = 6'($urandom);
            drive(rv, rnd_v, rnd);
            #4;
            iss = (|rv) & rnd_v;
            k = 0;
            for (int j = 0; j < NR; j++) if (bus.out_req_ready[j]) k = j;
            chk("grant_legal",
                {31'd0, $onehot0(bus.out_req_ready) && ((bus.out_req_ready & ~rv) == 4'b0000)},
                32'd1);
            if (iss && pend[k]) begin
                for (int j = 0; j < NR; j++) begin
                    if (j == k) chk("grant_wait", {31'd0, wait_cnt[j] < NR}, 32'd1);
                    else if (pend[j]) wait_cnt[j]++;
                end
            end
            check_cycle(iss, k, rnd);
            if (iss) pend[k] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 6'h00);
            #4;
            check_cycle(1'b0, 0, 6'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
